cache_req_arbiter: RTL and testbench
====================================

Name: cache_req_arbiter

Overview:
- Shares one set-associative cache model between NUM_REQ requesters (e.g. cores).
- Round-robin arbitration picks one requester at a time. The block issues a single lookup strobe to the cache, waits for the hit/miss verdict, models the refill delay on a miss, then returns a one-cycle response to the owner.
- Sits between the requesters and the cache hit/miss datapath; exactly one request is in flight at any time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 31, byte address width; matches the cache address port.
- MISS_PENALTY, 20, extra cycles spent in refill after a miss (0 allowed).
- CNT_W, 31, width of the statistics counters (used only with the optional feature).

Ports:
- clk_41  in  1  clock; all logic on posedge.
- rst_41  in  1  reset; synchronous, active-low.
- req_valid_41  in  NUM_REQ  per-requester request valid.
- req_addr_41  in  NUM_REQ*ADDR_W  packed addresses; requester r occupies bits [r*ADDR_W +: ADDR_W].
- req_ready_41  out  NUM_REQ  one-hot accept, driven combinationally.
- resp_valid_41  out  NUM_REQ  one-hot, one-cycle response pulse.
- resp_hit_41  out  1  hit(1)/miss(0) result; qualified by any resp_valid_41 bit.
- cache_req_41  out  1  one-cycle lookup strobe to the cache.
- cache_addr_41  out  ADDR_W  address to the cache; held from LOOKUP until the next grant.
- cache_hit_41  in  1  cache verdict: hit.
- cache_miss_41  in  1  cache verdict: miss.
- busy_41  out  1  high in every state except IDLE.

Behaviour:
- FSM states: IDLE, LOOKUP, WAIT_RSP, REFILL, RESP.
- Reset (rst_41 low at posedge), from any state, mid-transaction included:
  - state goes to IDLE; the round-robin pointer rr_ptr goes to 0; the refill counter goes to 0.
  - cache_addr_41 = 0; all outputs are 0.
  - Any in-flight transaction is dropped with no response.
- IDLE:
  - Winner = first requester with req_valid_41 set, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready_41 is high for the winner only. It is combinational and must not depend on req_ready_41 itself.
  - On the valid&ready handshake: latch the winner index as owner, latch its address, set rr_ptr = (winner+1) mod NUM_REQ, go to LOOKUP.
  - With no valid requests: stay in IDLE; rr_ptr is unchanged.
- LOOKUP: cache_req_41 = 1 for exactly this cycle; cache_addr_41 = latched address; go to WAIT_RSP.
- WAIT_RSP: wait with no timeout.
  - cache_hit_41 = 1: record hit, go to RESP.
  - cache_miss_41 = 1, MISS_PENALTY > 0: record miss, load the counter with MISS_PENALTY-1, go to REFILL.
  - cache_miss_41 = 1, MISS_PENALTY = 0: record miss, go directly to RESP.
  - Both verdicts high in the same cycle: treat as a miss.
  - Verdict inputs are ignored in every other state.
- REFILL: decrement the counter each cycle; go to RESP in the cycle the counter reads 0. Exactly MISS_PENALTY cycles are spent in REFILL.
- RESP: resp_valid_41[owner] = 1 for one cycle; resp_hit_41 = recorded result; go to IDLE.
- req_ready_41 is 0 in every state except IDLE, so there is no back-to-back accept; the minimum gap between grants is 4 cycles.
- Latency, counted from the handshake edge (cycle 0):
  - cache_req_41 is high in cycle 1.
  - Hit returned in cycle 2: resp_valid_41 in cycle 3.
  - Miss returned in cycle 2: resp_valid_41 in cycle 3+MISS_PENALTY.
- Requesters must hold req_valid_41 and req_addr_41 stable until granted. Dropping valid before the grant is legal; that requester is simply not considered.

Optional Feature:
- Macro: CACHE_ARB_STATS_EN.
- Defined:
  - Adds output ports hit_cnt_41 and miss_cnt_41, each NUM_REQ*CNT_W packed.
  - Per-requester counters increment in RESP according to resp_hit_41.
  - Counters wrap on overflow and clear on reset.
  - Counter values update on the edge that ends RESP.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single requester 0, addr 0x40, cache answers hit in cycle 2 -> resp_valid_41 = 0001 in cycle 3, resp_hit_41 = 1, busy_41 high in cycles 1-3.
- Requester 2 miss with MISS_PENALTY = 20 -> cache_req_41 in cycle 1, resp_valid_41 = 0100 in cycle 23, resp_hit_41 = 0; MISS_PENALTY = 0 -> response in cycle 3.
- All 4 requesters held valid continuously, every lookup a hit -> grant order 0,1,2,3,0,…; each grant 4 cycles apart; no requester is starved.
- cache_hit_41 and cache_miss_41 high together in WAIT_RSP -> REFILL entered, response carries resp_hit_41 = 0.
- rst_41 driven low during REFILL (counter at 7), released -> IDLE, no resp_valid_41 pulse, next grant goes to requester 0, cache_addr_41 = 0.
- With CACHE_ARB_STATS_EN: requester 1 gets 3 hits and 2 misses -> hit_cnt_41 slot 1 = 3, miss_cnt_41 slot 1 = 2, all other slots 0.

Source files
------------

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: round-robin arbiter sharing one cache lookup port; CACHE_ARB_STATS_EN adds per-requester hit/miss counters.
module cache_req_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 31,
  parameter int MISS_PENALTY = 20,
  parameter int CNT_W        = 31
) (
  input  logic                      clk_41,
  input  logic                      rst_41,
  input  logic [NUM_REQ-1:0]        req_valid_41,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_41,
  output logic [NUM_REQ-1:0]        req_ready_41,
  output logic [NUM_REQ-1:0]        resp_valid_41,
  output logic                      resp_hit_41,
  output logic                      cache_req_41,
  output logic [ADDR_W-1:0]         cache_addr_41,
  input  logic                      cache_hit_41,
  input  logic                      cache_miss_41,
  output logic                      busy_41
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]  hit_cnt_41,
  output logic [NUM_REQ*CNT_W-1:0]  miss_cnt_41
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = MISS_PENALTY > 1 ? $clog2(MISS_PENALTY) : 1;
  localparam logic [CW-1:0] LOAD = CW'(MISS_PENALTY > 0 ? MISS_PENALTY - 1 : 0);
  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_RSP, REFILL, RESP} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, owner, win;
  logic [CW-1:0] cnt;
  logic hit_r, any;
  // Scan from the highest offset down so the nearest requester at or after rr_ptr wins.
  always_comb begin
    win = '0;
    any = |req_valid_41;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid_41[IW'((int'(rr_ptr) + i) % NUM_REQ)]) win = IW'((int'(rr_ptr) + i) % NUM_REQ);
  end
  always_ff @(posedge clk_41)
    if (!rst_41) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    req_ready_41 = '0;
    resp_valid_41 = '0;
    cache_req_41 = state == LOOKUP;
    resp_hit_41 = state == RESP && hit_r;
    busy_41 = state != IDLE;
    case (state)
      IDLE: begin
        state_nxt = any ? LOOKUP : IDLE;
        req_ready_41[win] = any && rst_41;
      end
      LOOKUP: state_nxt = WAIT_RSP;
      WAIT_RSP: state_nxt = cache_miss_41 ? (MISS_PENALTY > 0 ? REFILL : RESP) : cache_hit_41 ? RESP : WAIT_RSP;
      REFILL: state_nxt = cnt == '0 ? RESP : REFILL;
      RESP: begin
        state_nxt = IDLE;
        resp_valid_41[owner] = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_41)
    if (!rst_41) begin
      rr_ptr <= '0;
      owner <= '0;
      cache_addr_41 <= '0;
      hit_r <= 1'b0;
      cnt <= '0;
    end else begin
      if (state == IDLE && any) begin
        owner <= win;
        cache_addr_41 <= req_addr_41[win*ADDR_W +: ADDR_W];
        rr_ptr <= IW'((int'(win) + 1) % NUM_REQ);
      end
      // A simultaneous hit and miss is resolved as a miss.
      if (state == WAIT_RSP && (cache_hit_41 || cache_miss_41)) hit_r <= !cache_miss_41;
      if (state == WAIT_RSP && cache_miss_41) cnt <= LOAD;
      else if (state == REFILL && cnt != '0) cnt <= cnt - 1'b1;
    end
`ifdef CACHE_ARB_STATS_EN
  always_ff @(posedge clk_41)
    if (!rst_41) begin
      hit_cnt_41 <= '0;
      miss_cnt_41 <= '0;
    end else if (state == RESP) begin
      if (hit_r) hit_cnt_41[owner*CNT_W +: CNT_W] <= hit_cnt_41[owner*CNT_W +: CNT_W] + 1'b1;
      else miss_cnt_41[owner*CNT_W +: CNT_W] <= miss_cnt_41[owner*CNT_W +: CNT_W] + 1'b1;
    end
`endif
endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb_cache_req_arbiter: directed self-checking bench; a second instance with zero miss penalty shares the stimulus.
module tb_cache_req_arbiter;
  localparam int N = 4, AW = 31, MP = 20, CW = 31;
  logic clk_41 = 1'b0, rst_41 = 1'b0;
  logic [N-1:0] req_valid_41, req_ready_41, resp_valid_41, req_ready0, resp_valid0, ev;
  logic [N*AW-1:0] req_addr_41;
  logic resp_hit_41, resp_hit0, cache_req_41, cache_req0, busy_41, busy0, cache_hit_41, cache_miss_41, seen;
  logic [AW-1:0] cache_addr_41, cache_addr0;
  int n_cmp = 0, n_err = 0, cyc;
`ifdef CACHE_ARB_STATS_EN
  logic [N*CW-1:0] hit_cnt_41, miss_cnt_41, hit_cnt0, miss_cnt0;
`endif
  always #5 clk_41 = ~clk_41;
  cache_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .MISS_PENALTY(MP), .CNT_W(CW)) u_dut (
    .clk_41(clk_41), .rst_41(rst_41), .req_valid_41(req_valid_41), .req_addr_41(req_addr_41),
    .req_ready_41(req_ready_41), .resp_valid_41(resp_valid_41), .resp_hit_41(resp_hit_41),
    .cache_req_41(cache_req_41), .cache_addr_41(cache_addr_41), .cache_hit_41(cache_hit_41),
    .cache_miss_41(cache_miss_41), .busy_41(busy_41)
`ifdef CACHE_ARB_STATS_EN
    , .hit_cnt_41(hit_cnt_41), .miss_cnt_41(miss_cnt_41)
`endif
  );
  cache_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .MISS_PENALTY(0), .CNT_W(CW)) u_dut0 (
    .clk_41(clk_41), .rst_41(rst_41), .req_valid_41(req_valid_41), .req_addr_41(req_addr_41),
    .req_ready_41(req_ready0), .resp_valid_41(resp_valid0), .resp_hit_41(resp_hit0),
    .cache_req_41(cache_req0), .cache_addr_41(cache_addr0), .cache_hit_41(cache_hit_41),
    .cache_miss_41(cache_miss_41), .busy_41(busy0)
`ifdef CACHE_ARB_STATS_EN
    , .hit_cnt_41(hit_cnt0), .miss_cnt_41(miss_cnt0)
`endif
  );
  task automatic tick();
    @(posedge clk_41);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_resp(input int start, input int exp_cyc, input logic [N-1:0] exp_v, input logic exp_hit, input string tag);
    cyc = start;
    while (resp_valid_41 == '0 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_resp"}, 64'(resp_valid_41), 64'(exp_v));
    chk({tag, "_hit"}, 64'(resp_hit_41), 64'(exp_hit));
  endtask
  initial begin
    req_valid_41 = '0;
    req_addr_41 = '0;
    cache_hit_41 = 1'b0;
    cache_miss_41 = 1'b0;
    repeat (2) tick();
    req_valid_41 = 4'b1111;
    #1;
    chk("rst_ready", 64'(req_ready_41), 64'h0);
    chk("rst_busy", 64'(busy_41), 64'h0);
    chk("rst_resp", 64'(resp_valid_41), 64'h0);
    chk("rst_creq", 64'(cache_req_41), 64'h0);
    chk("rst_addr", 64'(cache_addr_41), 64'h0);
    req_valid_41 = '0;
    rst_41 = 1'b1;
    tick();
    req_addr_41[0*AW +: AW] = 31'h40;
    req_addr_41[1*AW +: AW] = 31'h1111;
    req_addr_41[2*AW +: AW] = 31'h1234;
    req_addr_41[3*AW +: AW] = 31'h7ff;
    // single hit from requester 0
    req_valid_41 = 4'b0001;
    #1;
    chk("t1_ready", 64'(req_ready_41), 64'h1);
    tick();
    req_valid_41 = '0;
    chk("t1_creq", 64'(cache_req_41), 64'h1);
    chk("t1_addr", 64'(cache_addr_41), 64'h40);
    chk("t1_busy1", 64'(busy_41), 64'h1);
    tick();
    chk("t1_creq2", 64'(cache_req_41), 64'h0);
    chk("t1_busy2", 64'(busy_41), 64'h1);
    cache_hit_41 = 1'b1;
    tick();
    cache_hit_41 = 1'b0;
    chk("t1_resp", 64'(resp_valid_41), 64'h1);
    chk("t1_hit", 64'(resp_hit_41), 64'h1);
    chk("t1_busy3", 64'(busy_41), 64'h1);
    tick();
    chk("t1_resp_end", 64'(resp_valid_41), 64'h0);
    chk("t1_idle", 64'(busy_41), 64'h0);
    // requester 2 miss: 20-cycle refill vs zero-penalty instance
    req_valid_41 = 4'b0100;
    #1;
    chk("t2_ready", 64'(req_ready_41), 64'h4);
    tick();
    req_valid_41 = '0;
    chk("t2_creq", 64'(cache_req_41), 64'h1);
    chk("t2_addr", 64'(cache_addr_41), 64'h1234);
    tick();
    cache_miss_41 = 1'b1;
    tick();
    cache_miss_41 = 1'b0;
    chk("t2_mp0_resp", 64'(resp_valid0), 64'h4);
    chk("t2_mp0_hit", 64'(resp_hit0), 64'h0);
    chk("t2_noresp", 64'(resp_valid_41), 64'h0);
    wait_resp(3, 23, 4'b0100, 1'b0, "t2");
    tick();
    chk("t2_idle", 64'(busy_41), 64'h0);
    // all requesters valid, all hits: rr_ptr is 3 here
    req_valid_41 = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      ev = '0;
      ev[(3 + k) % N] = 1'b1;
      #1;
      chk($sformatf("rr_ready%0d", k), 64'(req_ready_41), 64'(ev));
      tick();
      tick();
      cache_hit_41 = 1'b1;
      tick();
      cache_hit_41 = 1'b0;
      chk($sformatf("rr_resp%0d", k), 64'(resp_valid_41), 64'(ev));
      chk($sformatf("rr_noacc%0d", k), 64'(req_ready_41), 64'h0);
      tick();
    end
    req_valid_41 = '0;
    // both verdicts at once count as a miss
    req_valid_41 = 4'b0010;
    #1;
    chk("t4_ready", 64'(req_ready_41), 64'h2);
    tick();
    req_valid_41 = '0;
    tick();
    cache_hit_41 = 1'b1;
    cache_miss_41 = 1'b1;
    tick();
    cache_hit_41 = 1'b0;
    cache_miss_41 = 1'b0;
    chk("t4_refill", 64'(busy_41 && resp_valid_41 == '0), 64'h1);
    chk("t4_mp0_hit", 64'(resp_hit0), 64'h0);
    wait_resp(3, 23, 4'b0010, 1'b0, "t4");
    tick();
    // reset mid-refill with counter at 7
    req_valid_41 = 4'b1000;
    #1;
    chk("t5_ready", 64'(req_ready_41), 64'h8);
    tick();
    req_valid_41 = '0;
    tick();
    cache_miss_41 = 1'b1;
    tick();
    cache_miss_41 = 1'b0;
    repeat (12) tick();
    rst_41 = 1'b0;
    tick();
    chk("t5_busy", 64'(busy_41), 64'h0);
    chk("t5_resp", 64'(resp_valid_41), 64'h0);
    chk("t5_addr", 64'(cache_addr_41), 64'h0);
    rst_41 = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      tick();
      seen |= resp_valid_41 != '0;
    end
    chk("t5_nopulse", 64'(seen), 64'h0);
    req_valid_41 = 4'b1111;
    #1;
    chk("t5_ready0", 64'(req_ready_41), 64'h1);
    tick();
    req_valid_41 = '0;
    chk("t5_addr0", 64'(cache_addr_41), 64'h40);
    tick();
    cache_hit_41 = 1'b1;
    tick();
    cache_hit_41 = 1'b0;
    chk("t5_resp0", 64'(resp_valid_41), 64'h1);
    tick();
`ifdef CACHE_ARB_STATS_EN
    rst_41 = 1'b0;
    tick();
    rst_41 = 1'b1;
    for (int t = 0; t < 5; t++) begin
      req_valid_41 = 4'b0010;
      tick();
      req_valid_41 = '0;
      tick();
      cache_hit_41 = t % 2 == 0;
      cache_miss_41 = t % 2 != 0;
      tick();
      cache_hit_41 = 1'b0;
      cache_miss_41 = 1'b0;
      wait_resp(3, t % 2 == 0 ? 3 : 3 + MP, 4'b0010, t % 2 == 0, $sformatf("st%0d", t));
      tick();
    end
    for (int s = 0; s < N; s++) begin
      chk($sformatf("hit_cnt%0d", s), 64'(hit_cnt_41[s*CW +: CW]), s == 1 ? 64'd3 : 64'd0);
      chk($sformatf("miss_cnt%0d", s), 64'(miss_cnt_41[s*CW +: CW]), s == 1 ? 64'd2 : 64'd0);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
